expr_pipe_eval: RTL and testbench



---
 rtl/expr_pipe_pkg.sv | 30 +++
 rtl/expr_pipe_eval_if.sv | 28 ++
 rtl/expr_pipe_eval_alu.sv | 47 ++++
 rtl/expr_pipe_eval.sv | 104 ++++++++++
 tb/tb_expr_pipe_eval.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/expr_pipe_pkg.sv
// Shared opcode encoding and width/range helpers for the expression pipeline.
package expr_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_SHL  = 3'd3,
    OP_ASR  = 3'd4,
    OP_GE   = 3'd5,
    OP_RXOR = 3'd6,
    OP_SEL  = 3'd7
  } expr_op_e;

  // Full-precision results are formed at this width; 2*WX must fit.
  localparam int CALC_W = 64;

  // Common operand width: wide enough for unsigned a as signed, and for b.
  function automatic int calc_wx(input int wa, input int wb);
    return (wa + 1 > wb) ? wa + 1 : wb;
  endfunction

  function automatic logic fits_signed(input logic signed [CALC_W-1:0] v, input int w);
    logic signed [CALC_W-1:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/expr_pipe_eval_if.sv
// Operand/result valid-ready bus of the expression pipeline.
interface expr_if #(
  parameter int WA = 4,
  parameter int WB = 5,
  parameter int WY = 6
);
  import expr_pipe_pkg::*;

  logic          in_valid;
  logic          in_ready;
  expr_op_e      in_op;
  logic [WA-1:0] in_a;
  logic [WB-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [WY-1:0] out_y;
  logic          out_ovf;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_ovf
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_ovf
  );
endinterface

// File: rtl/expr_pipe_eval_alu.sv
// Combinational evaluator: (op, ax, bx) -> truncated result and overflow flag.
module expr_alu
  import expr_pipe_pkg::*;
#(
  parameter int WA = 4,
  parameter int WB = 5,
  parameter int WX = 5,
  parameter int WY = 6
) (
  input  expr_op_e              op_i,
  input  logic signed [WX-1:0]  ax_i,
  input  logic signed [WX-1:0]  bx_i,
  output logic        [WY-1:0]  y_o,
  output logic                  ovf_o
);

  logic signed [CALC_W-1:0] axl, bxl, full;
  logic        [WA-1:0]     a_raw;
  logic        [WB-1:0]     b_raw;

  assign axl   = CALC_W'(ax_i);
  assign bxl   = CALC_W'(bx_i);
  // Original operand bits: shift amounts and parity use them, not the extensions.
  assign a_raw = ax_i[WA-1:0];
  assign b_raw = bx_i[WB-1:0];

  always_comb begin
    full  = '0;
    ovf_o = 1'b0;
    case (op_i)
      OP_ADD:  full = axl + bxl;
      OP_SUB:  full = axl - bxl;
      OP_MUL:  full = axl * bxl;
      OP_SHL:  full = (int'(b_raw) >= WY) ? '0 : (axl <<< b_raw);
      OP_ASR:  full = bxl >>> a_raw;
      OP_GE:   full = (axl >= bxl) ? 64'sd1 : 64'sd0;
      OP_RXOR: full = ((^a_raw) ^ (^b_raw)) ? 64'sd1 : 64'sd0;
      OP_SEL:  full = (a_raw != '0) ? bxl : axl;
      default: full = '0;
    endcase
    if (op_i inside {OP_ADD, OP_SUB, OP_MUL})
      ovf_o = !fits_signed(full, WY);
  end

  assign y_o = full[WY-1:0];

endmodule

// File: rtl/expr_pipe_eval.sv
// Two-stage valid/ready expression pipeline with a running result signature.
module expr_pipe_eval
  import expr_pipe_pkg::*;
#(
  parameter int WA = 4,
  parameter int WB = 5,
  parameter int WY = 6
) (
  input  logic          clk,
  input  logic          reset,
  expr_if.slave         bus,
  input  logic          csum_clr,
  output logic [WY-1:0] csum,
  output logic [15:0]   count
);

  localparam int WX = calc_wx(WA, WB);

  logic                 s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  expr_op_e             op_q, op_d;
  logic signed [WX-1:0] ax_q, ax_d, bx_q, bx_d;
  logic        [WY-1:0] y_q, y_d, csum_q, csum_d, alu_y;
  logic                 ovf_q, ovf_d, alu_ovf;
  logic        [15:0]   count_q, count_d;
  logic                 s1_ld, s2_ld, hs;

  expr_alu #(.WA(WA), .WB(WB), .WX(WX), .WY(WY)) u_alu (
    .op_i (op_q),
    .ax_i (ax_q),
    .bx_i (bx_q),
    .y_o  (alu_y),
    .ovf_o(alu_ovf)
  );

  always_comb begin
    s2_ld  = !s2_v_q || bus.out_ready;
    s1_ld  = !s1_v_q || s2_ld;
    hs     = s2_v_q && bus.out_ready;
    s1_v_d = s1_v_q;
    op_d   = op_q;
    ax_d   = ax_q;
    bx_d   = bx_q;
    s2_v_d = s2_v_q;
    y_d    = y_q;
    ovf_d  = ovf_q;
    if (s1_ld) begin
      s1_v_d = bus.in_valid;
      if (bus.in_valid) begin
        op_d = bus.in_op;
        ax_d = WX'(bus.in_a);
        bx_d = WX'(signed'(bus.in_b));
      end
    end
    if (s2_ld) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        y_d   = alu_y;
        ovf_d = alu_ovf;
      end
    end
    csum_d  = csum_q;
    count_d = count_q;
    // A clear that coincides with a handshake restarts the signature from that result.
    if (csum_clr) begin
      csum_d  = hs ? y_q : '0;
      count_d = hs ? 16'd1 : 16'd0;
    end else if (hs) begin
      csum_d  = {csum_q[WY-2:0], csum_q[WY-1]} ^ y_q;
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q  <= 1'b0;
      op_q    <= OP_ADD;
      ax_q    <= '0;
      bx_q    <= '0;
      s2_v_q  <= 1'b0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      csum_q  <= '0;
      count_q <= '0;
    end else begin
      s1_v_q  <= s1_v_d;
      op_q    <= op_d;
      ax_q    <= ax_d;
      bx_q    <= bx_d;
      s2_v_q  <= s2_v_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      csum_q  <= csum_d;
      count_q <= count_d;
    end
  end

  assign bus.in_ready  = s1_ld;
  assign bus.out_valid = s2_v_q;
  assign bus.out_y     = y_q;
  assign bus.out_ovf   = ovf_q;
  assign csum          = csum_q;
  assign count         = count_q;

endmodule

// File: tb/tb_expr_pipe_eval.sv
// Self-checking bench for expr_pipe_eval at default widths (WA=4, WB=5, WY=6).
module tb_expr_pipe_eval;
  import expr_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        csum_clr;
  logic [5:0]  csum;
  logic [15:0] count;
  int          checks = 0;
  int          errors = 0;

  expr_if #(.WA(4), .WB(5), .WY(6)) bus ();

  expr_pipe_eval #(.WA(4), .WB(5), .WY(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .csum_clr(csum_clr),
    .csum    (csum),
    .count   (count)
  );

  always #5 clk = ~clk;

  // Directed vectors: op, a, b and the expected result/overflow.
  logic [2:0] d_op  [10] = '{3'd0, 3'd2, 3'd1, 3'd4, 3'd3, 3'd3, 3'd5, 3'd6, 3'd7, 3'd7};
  logic [3:0] d_a   [10] = '{4'd15, 4'd15, 4'd0, 4'd2, 4'd3, 4'd1, 4'd0, 4'b0111, 4'd0, 4'd1};
  logic [4:0] d_b   [10] = '{5'h10, 5'h0F, 5'h10, 5'h10, 5'h03, 5'h06, 5'h1F, 5'b00001, 5'h1D, 5'h1D};
  logic [5:0] d_y   [10] = '{6'h3F, 6'h21, 6'h10, 6'h3C, 6'h18, 6'h00, 6'h01, 6'h00, 6'h00, 6'h3D};
  logic       d_ovf [10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Reference evaluation in plain integer arithmetic (WX=5, WY=6).
  function automatic void model(input logic [2:0] op, input logic [3:0] a, input logic [4:0] b,
                                output logic [5:0] y, output logic ovf);
    int av, bu, bv, full;
    av = int'(a);
    bu = int'(b);
    bv = (bu >= 16) ? bu - 32 : bu;
    case (op)
      3'd0: full = av + bv;
      3'd1: full = av - bv;
      3'd2: full = av * bv;
      3'd3: full = (bu >= 6) ? 0 : (av << bu);
      3'd4: full = (av >= 5) ? ((bv < 0) ? -1 : 0) : (bv >>> av);
      3'd5: full = (av >= bv) ? 1 : 0;
      3'd6: full = ($countones(a) + $countones(b)) % 2;
      default: full = (av != 0) ? bv : av;
    endcase
    y   = full[5:0];
    ovf = (op <= 3'd2) && ((full < -32) || (full > 31));
  endfunction

  // One clock: drive at negedge, sample outputs after settling, commit at posedge.
  task automatic step(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [4:0] b,
                      input logic rdy, input logic clr,
                      output logic in_hs, output logic ov, output logic [5:0] y, output logic ovf);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_op     = expr_op_e'(op);
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = rdy;
    csum_clr      = clr;
    #1;
    in_hs = v && bus.in_ready;
    ov    = bus.out_valid;
    y     = bus.out_y;
    ovf   = bus.out_ovf;
    @(posedge clk);
  endtask

  // Push one transaction into an idle pipe; lat = cycles from acceptance to result (-1 on timeout).
  task automatic run_one(input logic [2:0] op, input logic [3:0] a, input logic [4:0] b,
                         output logic [5:0] y, output logic ovf, output int lat);
    logic ih, ov, o;
    logic [5:0] yy;
    lat = -1; y = '0; ovf = 1'b0; ih = 1'b0;
    for (int t = 0; t < 10 && !ih; t++) step(1'b1, op, a, b, 1'b1, 1'b0, ih, ov, yy, o);
    if (ih) begin
      for (int n = 1; n <= 10; n++) begin
        step(1'b0, 3'd0, 4'd0, 5'd0, 1'b1, 1'b0, ih, ov, yy, o);
        if (ov) begin
          y = yy; ovf = o; lat = n;
          break;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; csum_clr = 1'b0;
    bus.in_valid = 1'b0; bus.in_op = OP_ADD; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got %b exp 0", bus.out_valid); end
    if (bus.out_y !== 6'h00) begin errors++; $display("FAIL reset out_y got %h exp 00", bus.out_y); end
    if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL reset out_ovf got %b exp 0", bus.out_ovf); end
    if (csum !== 6'h00) begin errors++; $display("FAIL reset csum got %h exp 00", csum); end
    if (count !== 16'h0) begin errors++; $display("FAIL reset count got %h exp 0000", count); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_directed;
    logic [5:0] y;
    logic ovf;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_one(d_op[i], d_a[i], d_b[i], y, ovf, lat);
      checks += 3;
      if (lat != 2) begin errors++; $display("FAIL directed[%0d] latency got %0d exp 2", i, lat); end
      if (y !== d_y[i]) begin errors++; $display("FAIL directed[%0d] y got %h exp %h", i, y, d_y[i]); end
      if (ovf !== d_ovf[i]) begin errors++; $display("FAIL directed[%0d] ovf got %b exp %b", i, ovf, d_ovf[i]); end
    end
  endtask

  task automatic test_backpressure;
    logic ih, ov, o;
    logic [5:0] yy, ey;
    logic eo;
    logic [5:0] exp_q[$];
    int acc = 0, nout = 0, first = -1, last = -1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 3'd0, 4'(acc + 1), 5'(acc + 2), 1'b0, 1'b0, ih, ov, yy, o);
      if (ih) begin
        model(3'd0, 4'(acc + 1), 5'(acc + 2), ey, eo);
        exp_q.push_back(ey);
        acc++;
      end
      if (k >= 2) begin
        checks++;
        if (ih !== 1'b0) begin errors++; $display("FAIL backpressure in_ready cycle %0d got 1 exp 0", k); end
      end
    end
    checks++;
    if (acc != 2) begin errors++; $display("FAIL backpressure accepted got %0d exp 2", acc); end
    for (int c = 0; c < 20 && nout < 4; c++) begin
      step(acc < 4, 3'd0, 4'(acc + 1), 5'(acc + 2), 1'b1, 1'b0, ih, ov, yy, o);
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL backpressure extra output got %h exp none", yy); end
        else begin
          ey = exp_q.pop_front();
          if (yy !== ey) begin errors++; $display("FAIL backpressure order y got %h exp %h", yy, ey); end
        end
        if (first < 0) first = c;
        last = c;
        nout++;
      end
      if (ih) begin
        model(3'd0, 4'(acc + 1), 5'(acc + 2), ey, eo);
        exp_q.push_back(ey);
        acc++;
      end
    end
    checks += 2;
    if (nout != 4) begin errors++; $display("FAIL backpressure outputs got %0d exp 4", nout); end
    if (last - first != 3) begin errors++; $display("FAIL backpressure spacing got %0d cycles exp 3", last - first); end
  endtask

  task automatic test_checksum;
    logic ih, ov, o;
    logic [5:0] yy;
    int lat;
    step(1'b0, 3'd0, 4'd0, 5'd0, 1'b1, 1'b1, ih, ov, yy, o);
    run_one(3'd0, 4'd1, 5'd0, yy, o, lat);
    run_one(3'd0, 4'd2, 5'd0, yy, o, lat);
    #1;
    checks += 2;
    if (csum !== 6'h00) begin errors++; $display("FAIL checksum pair csum got %h exp 00", csum); end
    if (count !== 16'd2) begin errors++; $display("FAIL checksum pair count got %0d exp 2", count); end
    step(1'b1, 3'd0, 4'd5, 5'd0, 1'b0, 1'b0, ih, ov, yy, o);
    step(1'b0, 3'd0, 4'd0, 5'd0, 1'b0, 1'b0, ih, ov, yy, o);
    step(1'b0, 3'd0, 4'd0, 5'd0, 1'b0, 1'b0, ih, ov, yy, o);
    step(1'b0, 3'd0, 4'd0, 5'd0, 1'b1, 1'b1, ih, ov, yy, o);
    #1;
    checks += 3;
    if (!(ov && yy === 6'h05)) begin errors++; $display("FAIL checksum clr_hs y got %h valid %b exp 05 valid 1", yy, ov); end
    if (csum !== 6'h05) begin errors++; $display("FAIL checksum clr_hs csum got %h exp 05", csum); end
    if (count !== 16'd1) begin errors++; $display("FAIL checksum clr_hs count got %0d exp 1", count); end
  endtask

  task automatic test_random;
    logic ih, ov, o, v, rdy, clr, eo, hold;
    logic [2:0] op;
    logic [3:0] a;
    logic [4:0] b;
    logic [5:0] yy, ey, prev_y, m_csum;
    logic [15:0] m_count;
    logic [5:0] qy[$];
    logic       qo[$];
    step(1'b0, 3'd0, 4'd0, 5'd0, 1'b1, 1'b1, ih, ov, yy, o);
    m_csum = '0; m_count = '0; hold = 1'b0; prev_y = '0;
    for (int c = 0; c < 420; c++) begin
      v   = (c < 400) && ($urandom_range(0, 3) != 0);
      op  = 3'($urandom);
      a   = 4'($urandom);
      b   = 5'($urandom);
      rdy = ($urandom_range(0, 3) != 0) || (c >= 400);
      clr = ($urandom_range(0, 40) == 0);
      step(v, op, a, b, rdy, clr, ih, ov, yy, o);
      if (hold) begin
        checks++;
        if (!(ov && yy === prev_y)) begin errors++; $display("FAIL random stall y got %h valid %b exp %h valid 1", yy, ov, prev_y); end
      end
      if (ov && rdy) begin
        checks++;
        if (qy.size() == 0) begin errors++; $display("FAIL random extra output got %h exp none", yy); end
        else begin
          ey = qy.pop_front();
          eo = qo.pop_front();
          if (yy !== ey || o !== eo) begin errors++; $display("FAIL random op result y=%h ovf=%b exp y=%h ovf=%b", yy, o, ey, eo); end
          m_csum  = clr ? ey : ({m_csum[4:0], m_csum[5]} ^ ey);
          m_count = clr ? 16'd1 : m_count + 16'd1;
        end
      end else if (clr) begin
        m_csum = '0; m_count = '0;
      end
      if (ih) begin
        model(op, a, b, ey, eo);
        qy.push_back(ey);
        qo.push_back(eo);
      end
      hold   = ov && !rdy;
      prev_y = yy;
    end
    #1;
    checks += 3;
    if (qy.size() != 0) begin errors++; $display("FAIL random drain left got %0d exp 0", qy.size()); end
    if (csum !== m_csum) begin errors++; $display("FAIL random csum got %h exp %h", csum, m_csum); end
    if (count !== m_count) begin errors++; $display("FAIL random count got %0d exp %0d", count, m_count); end
  endtask

  task automatic test_reset_mid;
    logic ih, ov, o;
    logic [5:0] yy;
    int lat;
    run_one(3'd0, 4'd1, 5'd1, yy, o, lat);
    step(1'b1, 3'd0, 4'd7, 5'd3, 1'b0, 1'b0, ih, ov, yy, o);
    step(1'b1, 3'd2, 4'd9, 5'd9, 1'b0, 1'b0, ih, ov, yy, o);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks += 5;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midreset out_valid got %b exp 0", bus.out_valid); end
    if (bus.out_y !== 6'h00) begin errors++; $display("FAIL midreset out_y got %h exp 00", bus.out_y); end
    if (bus.out_ovf !== 1'b0) begin errors++; $display("FAIL midreset out_ovf got %b exp 0", bus.out_ovf); end
    if (csum !== 6'h00) begin errors++; $display("FAIL midreset csum got %h exp 00", csum); end
    if (count !== 16'h0) begin errors++; $display("FAIL midreset count got %0d exp 0", count); end
    @(negedge clk);
    reset = 1'b0;
    run_one(3'd0, 4'd3, 5'd1, yy, o, lat);
    #1;
    checks += 3;
    if (lat != 2) begin errors++; $display("FAIL midreset latency got %0d exp 2", lat); end
    if (yy !== 6'h04) begin errors++; $display("FAIL midreset y got %h exp 04", yy); end
    if (count !== 16'd1) begin errors++; $display("FAIL midreset count got %0d exp 1", count); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_checksum();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
